fta_asynch2sync_q: RTL and testbench

//  Parametrised, queued successor of the single-entry async-to-sync request latch. Accepts pulsed
//  bus requests from a foreign-timed master, buffers up to DEPTH in a FIFO and replays them one at
//  a time to a synchronous target as a held-cyc cycle. Returns one single-cycle response pulse
//  per completed request. Sits between pulse-style masters (bridges, DMA) and the fta target bus.

---
 rtl/fta_asynch2sync_q.sv | 196 +++++++++++++++++++
 tb/tb_fta_asynch2sync_q.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fta_asynch2sync_q.sv
// fta_asynch2sync_q: buffers pulsed requests from a foreign-timed master in a
// DEPTH-entry FIFO and replays them one at a time to a synchronous target as a
// held cyc cycle, returning one single-cycle response pulse per request.
// Optional feature: define FTA_A2S_TIMEOUT_EN to abort a silent target with an
// error response after TMO busy cycles.
module fta_asynch2sync_q #(
    parameter int AW    = 32,
    parameter int DW    = 128,
    parameter int TIDW  = 8,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_cyc_i,
    input  logic              req_we_i,
    input  logic [AW-1:0]     req_adr_i,
    input  logic [DW-1:0]     req_dat_i,
    input  logic [DW/8-1:0]   req_sel_i,
    input  logic [TIDW-1:0]   req_tid_i,
    output logic              req_full_o,
    output logic              req_ovf_o,
    output logic              req_cyc_o,
    output logic              req_we_o,
    output logic [AW-1:0]     req_adr_o,
    output logic [DW-1:0]     req_dat_o,
    output logic [DW/8-1:0]   req_sel_o,
    output logic [TIDW-1:0]   req_tid_o,
    input  logic              resp_ack_i,
    input  logic              resp_err_i,
    input  logic              resp_rty_i,
    input  logic [DW-1:0]     resp_dat_i,
    output logic              resp_ack_o,
    output logic              resp_err_o,
    output logic              resp_rty_o,
    output logic [DW-1:0]     resp_dat_o,
    output logic [TIDW-1:0]   resp_tid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = DW / 8;
    localparam int EW = 1 + AW + DW + SW + TIDW;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        REL
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0]   mem [DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr, count;
    logic [EW-1:0]   head;
    logic            h_we;
    logic [AW-1:0]   h_adr;
    logic [DW-1:0]   h_dat;
    logic [SW-1:0]   h_sel;
    logic [TIDW-1:0] h_tid;

    logic empty, full, push, pop;
    logic aer, aer_q, evt, tmo_hit, ovf;

    logic            rsp_ack, rsp_err, rsp_rty;
    logic [DW-1:0]   rsp_dat;
    logic [TIDW-1:0] rsp_tid;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign aer  = resp_ack_i | resp_err_i | resp_rty_i;
    assign evt  = aer & ~aer_q;
    assign pop  = (state == BUSY) & (evt | tmo_hit);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign push = req_cyc_i & (~full | pop);

    assign head = mem[rd_ptr[PW-1:0]];
    assign {h_we, h_adr, h_dat, h_sel, h_tid} = head;

    // Request storage; contents are only visible while BUSY, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {req_we_i, req_adr_i, req_dat_i, req_sel_i, req_tid_i};
        end
    end

    // FIFO pointers, sticky overflow flag and registered completion level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            aer_q  <= 1'b0;
        end else begin
            aer_q <= aer;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (req_cyc_i && !push) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef FTA_A2S_TIMEOUT_EN
    localparam int CW0 = $clog2(TMO + 1);
    localparam int CW  = (CW0 < 8) ? 8 : ((CW0 > 16) ? 16 : CW0);

    logic [CW-1:0] tmo_cnt;

    // Busy-cycle counter; held at zero outside BUSY so it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires in the TMO-th busy cycle so the error pulse lands TMO cycles after entry.
    assign tmo_hit = (state == BUSY) && (tmo_cnt == CW'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: issue head, wait for completion edge, then wait for release.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!empty)          state_nx = BUSY;
            BUSY:    if (evt || tmo_hit)  state_nx = REL;
            REL:     if (!aer)            state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // One-cycle response pulse, err > rty > ack; a timeout reports err with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rty <= 1'b0;
            rsp_dat <= '0;
            rsp_tid <= '0;
        end else begin
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rty <= 1'b0;
            rsp_dat <= '0;
            rsp_tid <= '0;
            if (state == BUSY && evt) begin
                rsp_err <= resp_err_i;
                rsp_rty <= resp_rty_i & ~resp_err_i;
                rsp_ack <= resp_ack_i & ~resp_err_i & ~resp_rty_i;
                rsp_dat <= resp_dat_i;
                rsp_tid <= h_tid;
            end else if (tmo_hit) begin
                rsp_err <= 1'b1;
                rsp_tid <= h_tid;
            end
        end
    end

    assign req_full_o = full;
    assign req_ovf_o  = ovf;
    assign req_cyc_o  = (state == BUSY);
    assign req_we_o   = req_cyc_o & h_we;
    assign req_adr_o  = req_cyc_o ? h_adr : '0;
    assign req_dat_o  = req_cyc_o ? h_dat : '0;
    assign req_sel_o  = req_cyc_o ? h_sel : '0;
    assign req_tid_o  = req_cyc_o ? h_tid : '0;

    assign resp_ack_o = rsp_ack;
    assign resp_err_o = rsp_err;
    assign resp_rty_o = rsp_rty;
    assign resp_dat_o = rsp_dat;
    assign resp_tid_o = rsp_tid;

endmodule

// File: tb/tb_fta_asynch2sync_q.sv
// Testbench for fta_asynch2sync_q: response-priority vector table, directed
// latency/burst/overflow/reset/level/timeout sequences, and a randomized run
// against a queue-based reference model with a reactive target.
module tb_fta_asynch2sync_q;

    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int TIDW  = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic              cyc_i, we_i;
    logic [AW-1:0]     adr_i;
    logic [DW-1:0]     dat_i;
    logic [DW/8-1:0]   sel_i;
    logic [TIDW-1:0]   tid_i;
    logic              full_o, ovf_o, cyc_o, we_o;
    logic [AW-1:0]     adr_o;
    logic [DW-1:0]     dat_o;
    logic [DW/8-1:0]   sel_o;
    logic [TIDW-1:0]   tid_o;
    logic              ack_i, err_i, rty_i;
    logic [DW-1:0]     rdat_i;
    logic              ack_o, err_o, rty_o;
    logic [DW-1:0]     rdat_o;
    logic [TIDW-1:0]   rtid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fta_asynch2sync_q #(
        .AW(AW), .DW(DW), .TIDW(TIDW), .DEPTH(DEPTH), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_cyc_i(cyc_i), .req_we_i(we_i), .req_adr_i(adr_i), .req_dat_i(dat_i),
        .req_sel_i(sel_i), .req_tid_i(tid_i),
        .req_full_o(full_o), .req_ovf_o(ovf_o),
        .req_cyc_o(cyc_o), .req_we_o(we_o), .req_adr_o(adr_o), .req_dat_o(dat_o),
        .req_sel_o(sel_o), .req_tid_o(tid_o),
        .resp_ack_i(ack_i), .resp_err_i(err_i), .resp_rty_i(rty_i), .resp_dat_i(rdat_i),
        .resp_ack_o(ack_o), .resp_err_o(err_o), .resp_rty_o(rty_o),
        .resp_dat_o(rdat_o), .resp_tid_o(rtid_o)
    );

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
        logic [DW/8-1:0] sel;
        logic [TIDW-1:0] tid;
    } ent_t;

    typedef struct {
        logic            a, e, r;
        logic [TIDW-1:0] tid;
        logic [DW-1:0]   rd;
        logic            xa, xe, xr;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cyc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0; tid_i = '0;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; rdat_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drive one request for the current cycle; returns in the following cycle.
    task automatic push_one(input logic [TIDW-1:0] tid, input logic [AW-1:0] adr, input logic we);
        cyc_i = 1'b1; we_i = we; adr_i = adr; tid_i = tid;
        dat_i = {96'h0, adr} + DW'(tid); sel_i = '1;
        tick();
        cyc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0; tid_i = '0;
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (!cyc_o && n < 12) begin
            tick();
            n++;
        end
        chk(name, cyc_o, 1'b1);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        clear_inputs();

        // Response priority table: err > rty > ack.
        vt[0] = '{a:1'b1, e:1'b0, r:1'b0, tid:8'h21, rd:128'h0123_4567_89ab_cdef_0011_2233_4455_6677, xa:1'b1, xe:1'b0, xr:1'b0};
        vt[1] = '{a:1'b0, e:1'b1, r:1'b0, tid:8'h22, rd:128'hdead_beef_0000_0000_0000_0000_0000_0001, xa:1'b0, xe:1'b1, xr:1'b0};
        vt[2] = '{a:1'b0, e:1'b0, r:1'b1, tid:8'h23, rd:128'h1, xa:1'b0, xe:1'b0, xr:1'b1};
        vt[3] = '{a:1'b1, e:1'b1, r:1'b0, tid:8'h24, rd:128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, xa:1'b0, xe:1'b1, xr:1'b0};
        vt[4] = '{a:1'b1, e:1'b0, r:1'b1, tid:8'h25, rd:128'h5555, xa:1'b0, xe:1'b0, xr:1'b1};
        vt[5] = '{a:1'b0, e:1'b1, r:1'b1, tid:8'h26, rd:128'haaaa, xa:1'b0, xe:1'b1, xr:1'b0};
        vt[6] = '{a:1'b1, e:1'b1, r:1'b1, tid:8'h27, rd:128'h7, xa:1'b0, xe:1'b1, xr:1'b0};

        // Reset state.
        #1 rst_n = 1'b0;
        tick();
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rty", rty_o, 1'b0);
        chk("rst_rdat", rdat_o, '0);
        chk("rst_rtid", rtid_o, '0);
        chk("rst_adr", adr_o, '0);
        rst_n = 1'b1;
        tick();

        // Single read with latency checks.
        push_one(8'h11, 32'h1000, 1'b0);
        chk("lat_n1_cyc", cyc_o, 1'b0);
        tick();
        chk("lat_n2_cyc", cyc_o, 1'b1);
        chk("rd_adr", adr_o, 32'h1000);
        chk("rd_tid", tid_o, 8'h11);
        chk("rd_we", we_o, 1'b0);
        chk("rd_sel", sel_o, 16'hffff);
        chk("rd_dat", dat_o, 128'h1011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_cyc_held", cyc_o, 1'b1);
            chk("rd_no_early_ack", ack_o, 1'b0);
        end
        ack_i = 1'b1;
        rdat_i = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
        tick();
        chk("rd_ack", ack_o, 1'b1);
        chk("rd_resp_tid", rtid_o, 8'h11);
        chk("rd_resp_dat", rdat_o, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
        chk("rd_cyc_drop", cyc_o, 1'b0);
        chk("rd_adr_drop", adr_o, '0);
        ack_i = 1'b0;
        rdat_i = '0;
        tick();
        chk("rd_ack_1cyc", ack_o, 1'b0);
        chk("rd_dat_zero", rdat_o, '0);
        chk("rd_tid_zero", rtid_o, '0);
        tick();
        chk("rd_idle", cyc_o, 1'b0);

        // Table-driven response priority.
        for (int i = 0; i < 7; i++) begin
            push_one(vt[i].tid, AW'(i * 16), i[0]);
            wait_cyc("tbl_wait_cyc");
            chk("tbl_head_tid", tid_o, vt[i].tid);
            ack_i = vt[i].a; err_i = vt[i].e; rty_i = vt[i].r; rdat_i = vt[i].rd;
            tick();
            chk("tbl_ack", ack_o, vt[i].xa);
            chk("tbl_err", err_o, vt[i].xe);
            chk("tbl_rty", rty_o, vt[i].xr);
            chk("tbl_dat", rdat_o, vt[i].rd);
            chk("tbl_tid", rtid_o, vt[i].tid);
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; rdat_i = '0;
            tick();
            chk("tbl_pulse_end", {ack_o, err_o, rty_o}, 3'b000);
            tick();
        end

        // Burst of four, fifth push dropped while full, in-order completion.
        begin
            logic [TIDW-1:0] tids[$];
            int hold = 0;
            do_reset();
            for (int k = 1; k <= 4; k++) push_one(TIDW'(k), AW'(k * 32'h100), 1'b1);
            chk("burst_full", full_o, 1'b1);
            chk("burst_no_ovf", ovf_o, 1'b0);
            push_one(8'h05, 32'h500, 1'b1);
            chk("ovf_set", ovf_o, 1'b1);
            chk("ovf_full", full_o, 1'b1);
            for (int t = 0; t < 60; t++) begin
                if (ack_o) begin
                    tids.push_back(rtid_o);
                    chk("burst_gap", cyc_o, 1'b0);
                end
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) ack_i = 1'b0;
                end else if (cyc_o) begin
                    ack_i = 1'b1;
                    rdat_i = rnd128();
                    hold = 2;
                end
                tick();
            end
            chk("burst_count", tids.size(), 4);
            for (int k = 0; k < 4; k++) begin
                chk("burst_order", (k < tids.size()) ? tids[k] : 8'hff, TIDW'(k + 1));
            end
            chk("burst_ovf_sticky", ovf_o, 1'b1);
            chk("burst_empty", full_o, 1'b0);
            chk("burst_idle", cyc_o, 1'b0);
        end

        // Asynchronous reset in the middle of a response pulse with a full queue.
        do_reset();
        for (int k = 0; k < 5; k++) push_one(TIDW'(8'h60 + k), 32'h2000, 1'b0);
        wait_cyc("mrst_wait_cyc");
        ack_i = 1'b1;
        rdat_i = 128'h1234;
        tick();
        chk("mrst_pre_ack", ack_o, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_cyc", cyc_o, 1'b0);
        chk("mrst_ack", ack_o, 1'b0);
        chk("mrst_rdat", rdat_o, '0);
        chk("mrst_rtid", rtid_o, '0);
        chk("mrst_full", full_o, 1'b0);
        chk("mrst_ovf", ovf_o, 1'b0);
        chk("mrst_tid", tid_o, '0);
        ack_i = 1'b0;
        rdat_i = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_stays_empty", {cyc_o, full_o, ack_o}, 3'b000);
        end

        // A completion level already high on entering BUSY is not an event.
        do_reset();
        ack_i = 1'b1;
        rdat_i = 128'hbeef;
        push_one(8'h33, 32'h3300, 1'b0);
        wait_cyc("lvl_wait_cyc");
        for (int i = 0; i < 4; i++) begin
            chk("lvl_no_pulse", ack_o, 1'b0);
            chk("lvl_cyc_held", cyc_o, 1'b1);
            tick();
        end
        ack_i = 1'b0;
        tick();
        ack_i = 1'b1;
        tick();
        chk("lvl_edge_ack", ack_o, 1'b1);
        chk("lvl_edge_tid", rtid_o, 8'h33);
        ack_i = 1'b0;
        rdat_i = '0;
        tick();
        tick();

`ifdef FTA_A2S_TIMEOUT_EN
        // Silent target: error pulse TMO cycles after BUSY entry, then next entry issues.
        do_reset();
        push_one(8'h41, 32'h4100, 1'b0);
        push_one(8'h42, 32'h4200, 1'b0);
        chk("tmo_busy", cyc_o, 1'b1);
        chk("tmo_head", tid_o, 8'h41);
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_no_early", err_o, 1'b0);
            tick();
        end
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_ack", ack_o, 1'b0);
        chk("tmo_tid", rtid_o, 8'h41);
        chk("tmo_dat", rdat_o, '0);
        chk("tmo_cyc_drop", cyc_o, 1'b0);
        tick();
        tick();
        chk("tmo_next_cyc", cyc_o, 1'b1);
        chk("tmo_next_tid", tid_o, 8'h42);
        ack_i = 1'b1;
        tick();
        chk("tmo_next_ack", ack_o, 1'b1);
        chk("tmo_next_rtid", rtid_o, 8'h42);
        ack_i = 1'b0;
        tick();
        tick();
`endif

        // Randomized run against a queue model with a reactive target.
        begin
            ent_t mq[$];
            ent_t ent;
            bit ovf_x = 1'b0;
            bit rsp_v = 1'b0;
            logic x_a = 1'b0, x_e = 1'b0, x_r = 1'b0;
            logic [DW-1:0] x_dat = '0;
            logic [TIDW-1:0] x_tid = '0;
            bit aer_on = 1'b0, prev_aer = 1'b0, rise;
            int hold = 0, dly = 0, starve = 0, max_starve = 0, pops = 0;
            logic [2:0] aer_typ = 3'b100;
            logic [DW-1:0] aer_dat = '0;
            do_reset();
            for (int t = 0; t < 800; t++) begin
                chk("rnd_full", full_o, mq.size() == DEPTH);
                chk("rnd_ovf", ovf_o, ovf_x);
                chk("rnd_ack", ack_o, rsp_v & x_a);
                chk("rnd_err", err_o, rsp_v & x_e);
                chk("rnd_rty", rty_o, rsp_v & x_r);
                chk("rnd_rdat", rdat_o, rsp_v ? x_dat : '0);
                chk("rnd_rtid", rtid_o, rsp_v ? x_tid : '0);
                if (cyc_o && mq.size() == 0) begin
                    chk("rnd_cyc_empty", cyc_o, 1'b0);
                end else if (cyc_o) begin
                    chk("rnd_we", we_o, mq[0].we);
                    chk("rnd_adr", adr_o, mq[0].adr);
                    chk("rnd_dat", dat_o, mq[0].dat);
                    chk("rnd_sel", sel_o, mq[0].sel);
                    chk("rnd_tid", tid_o, mq[0].tid);
                end else begin
                    chk("rnd_idle_fields", {we_o, adr_o, sel_o, tid_o} | DW'(dat_o), '0);
                end
                if (mq.size() > 0 && !cyc_o) starve++;
                else starve = 0;
                if (starve > max_starve) max_starve = starve;

                // Target: respond after a random delay, hold the level 1..3 cycles.
                if (aer_on) begin
                    hold--;
                    if (hold == 0) aer_on = 1'b0;
                end else if (cyc_o) begin
                    if (dly == 0) begin
                        aer_on = 1'b1;
                        hold = int'($urandom_range(3, 1));
                        aer_typ = 3'($urandom_range(7, 1));
                        aer_dat = rnd128();
                        dly = int'($urandom_range(3, 0));
                    end else begin
                        dly--;
                    end
                end
                {ack_i, err_i, rty_i} = aer_on ? aer_typ : 3'b000;
                rdat_i = aer_on ? aer_dat : '0;

                // Master: alternate heavy and light push phases.
                cyc_i = ($urandom_range(3, 0) < (((t / 40) % 2 == 0) ? 3 : 1));
                ent = '{we: 1'($urandom()), adr: $urandom(), dat: rnd128(),
                        sel: 16'($urandom()), tid: 8'($urandom())};
                we_i = cyc_i ? ent.we : 1'b0;
                adr_i = cyc_i ? ent.adr : '0;
                dat_i = cyc_i ? ent.dat : '0;
                sel_i = cyc_i ? ent.sel : '0;
                tid_i = cyc_i ? ent.tid : '0;

                rise = aer_on && !prev_aer;
                tick();

                rsp_v = rise;
                if (rise) begin
                    pops++;
                    if (aer_typ[1]) begin
                        x_e = 1'b1; x_r = 1'b0; x_a = 1'b0;
                    end else if (aer_typ[0]) begin
                        x_e = 1'b0; x_r = 1'b1; x_a = 1'b0;
                    end else begin
                        x_e = 1'b0; x_r = 1'b0; x_a = 1'b1;
                    end
                    x_dat = aer_dat;
                    if (mq.size() > 0) begin
                        x_tid = mq[0].tid;
                        void'(mq.pop_front());
                    end else begin
                        x_tid = '0;
                    end
                end
                if (cyc_i) begin
                    if (mq.size() < DEPTH) mq.push_back(ent);
                    else ovf_x = 1'b1;
                end
                prev_aer = aer_on;
            end
            clear_inputs();
            chk("rnd_max_starve_ok", max_starve <= 8, 1'b1);
            chk("rnd_made_progress", pops > 50, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
